clb_cfg_loader: RTL and testbench

CLB_CFG_LOADER -- requirements
Module: clb_cfg_loader

---
 rtl/clb_cfg_loader_pkg.sv | 28 ++
 rtl/clb_cfg_shadow.sv | 34 +++
 rtl/clb_cfg_loader.sv | 158 +++++++++++++++
 tb/tb_clb_cfg_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clb_cfg_loader_pkg.sv
// Shared definitions for the CLB configuration loader: FSM states, the
// committed-vector field map and the default frame header.
package clb_cfg_loader_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;
  localparam int CFG_W  = 146;

  localparam int BYP_LSB = 0;
  localparam int BYP_W   = 16;
  localparam int SEL_LSB = 16;
  localparam int SEL_W   = 96;
  localparam int OP_LSB  = 112;
  localparam int OP_W    = 32;
  localparam int OUT_LSB = 144;
  localparam int OUT_W   = 2;

  localparam logic [WORD_W-1:0] DEFAULT_MAGIC = 16'hC1B0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CSUM,
    ST_CHECK,
    ST_COMMIT
  } state_t;

endpackage

// File: rtl/clb_cfg_shadow.sv
// Word-addressed shadow register that collects a frame's payload before it
// is checked; nothing here is visible outside the loader until commit.
module clb_cfg_shadow
  import clb_cfg_loader_pkg::*;
#(
  parameter int WORDS = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we_i,
  input  logic [CNT_W-1:0]        addr_i,
  input  logic [WORD_W-1:0]       wdata_i,
  output logic [WORDS*WORD_W-1:0] data_o
);

  logic [WORDS*WORD_W-1:0] data_q;

  // NOTE: the shadow is plain flops with an async reset, so it clears with
  // the rest of the loader instead of holding an undefined previous frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      for (int w = 0; w < WORDS; w++) begin
        if (we_i && addr_i == CNT_W'(w)) begin
          data_q[w*WORD_W +: WORD_W] <= wdata_i;
        end
      end
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/clb_cfg_loader.sv
// Streams a header/payload/checksum frame into a shadow register and commits
// the CLB configuration vector atomically only after the frame checks out.
module clb_cfg_loader
  import clb_cfg_loader_pkg::*;
#(
  parameter logic [WORD_W-1:0] MAGIC         = DEFAULT_MAGIC,
  parameter int                PAYLOAD_WORDS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              abort,
  output logic [CFG_W-1:0]  cfg_out,
  output logic              cfg_valid,
  output logic              cfg_update,
  output logic              err,
  output logic              busy
);

  localparam int               SHADOW_W  = PAYLOAD_WORDS * WORD_W;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PAYLOAD_WORDS - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   xor_q, xor_d;
  logic [WORD_W-1:0]   csum_q, csum_d;
  logic [CFG_W-1:0]    cfg_q, cfg_d;
  logic                valid_q, valid_d;
  logic                upd_q, upd_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic                shadow_we;
  logic [SHADOW_W-1:0] shadow;
  logic [CFG_W-1:0]    cfg_fields;
  logic                xfer;
  logic                pass;

  clb_cfg_shadow #(
    .WORDS (PAYLOAD_WORDS)
  ) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (shadow_we),
    .addr_i  (cnt_q),
    .wdata_i (s_data),
    .data_o  (shadow)
  );

  assign xfer = s_valid && s_ready;
  assign pass = (csum_q == xor_q) && (shadow[SHADOW_W-1:CFG_W] == '0);

  assign cfg_fields = {shadow[OUT_LSB +: OUT_W], shadow[OP_LSB +: OP_W],
                       shadow[SEL_LSB +: SEL_W], shadow[BYP_LSB +: BYP_W]};

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    xor_d     = xor_q;
    csum_d    = csum_q;
    cfg_d     = cfg_q;
    valid_d   = valid_q;
    upd_d     = 1'b0;
    err_d     = 1'b0;
    shadow_we = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      xor_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            if (s_data == MAGIC) begin
              state_d = ST_LOAD;
              cnt_d   = '0;
              xor_d   = '0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            shadow_we = 1'b1;
            xor_d     = xor_q ^ s_data;
            if (cnt_q == LAST_WORD) begin
              cnt_d   = '0;
              state_d = ST_CSUM;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_CSUM: begin
          if (xfer) begin
            csum_d  = s_data;
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (pass) begin
            state_d = ST_COMMIT;
            cfg_d   = cfg_fields;
            valid_d = 1'b1;
            upd_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
        ST_COMMIT: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end

    // Registered so that s_ready stays low throughout reset.
    ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_CSUM);
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      xor_q   <= '0;
      csum_q  <= '0;
      cfg_q   <= '0;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xor_q   <= xor_d;
      csum_q  <= csum_d;
      cfg_q   <= cfg_d;
      valid_q <= valid_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign s_ready    = ready_q;
  assign cfg_out    = cfg_q;
  assign cfg_valid  = valid_q;
  assign cfg_update = upd_q;
  assign err        = err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed self-checking bench for clb_cfg_loader: commit timing, rejected
// frames, abort, backpressure and asynchronous reset.
module tb_clb_cfg_loader;

  localparam logic [15:0] MAGIC = 16'hC1B0;
  localparam logic [145:0] CFG_W9_1 = 146'h1 << 144;
  localparam logic [145:0] CFG_W9_3 = 146'h3 << 144;

  logic         clk;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [15:0]  s_data;
  logic         abort;
  logic [145:0] cfg_out;
  logic         cfg_valid;
  logic         cfg_update;
  logic         err;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] pl [10];
  bit          bp_mode = 0;
  int          rdy_low_cnt = 0;

  // Sampled around the end of a frame: CHECK cycle, next cycle, one after.
  logic         o0_upd, o0_rdy;
  logic [145:0] o0_cfg;
  logic         o1_upd, o1_err, o1_valid, o1_rdy, o1_busy;
  logic [145:0] o1_cfg;
  logic         o2_upd, o2_err, o2_rdy, o2_busy;

  clb_cfg_loader #(
    .MAGIC         (MAGIC),
    .PAYLOAD_WORDS (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .abort      (abort),
    .cfg_out    (cfg_out),
    .cfg_valid  (cfg_valid),
    .cfg_update (cfg_update),
    .err        (err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pl_xor();
    logic [15:0] x = '0;
    for (int k = 0; k < 10; k++) x ^= pl[k];
    return x;
  endfunction

  function automatic logic [145:0] pl_pack();
    logic [159:0] s;
    for (int k = 0; k < 10; k++) s[16*k +: 16] = pl[k];
    return s[145:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] d);
    int  waited = 0;
    bit  done   = 0;
    bit  rdy_now;
    if (bp_mode) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        s_valid = 1'b0;
        s_data  = 16'($urandom);
        if (!s_ready) rdy_low_cnt++;
        tick();
      end
    end
    s_valid = 1'b1;
    s_data  = d;
    while (!done && waited < 50) begin
      rdy_now = s_ready;
      tick();
      waited++;
      if (rdy_now) done = 1;
    end
    s_valid = 1'b0;
    if (!done) begin
      n_assert++; n_fail++;
      $display("FAIL send_word_timeout: word %h not accepted within 50 cycles", d);
    end
  endtask

  task automatic run_frame(input logic [15:0] csum);
    send_word(MAGIC);
    for (int k = 0; k < 10; k++) send_word(pl[k]);
    send_word(csum);
    o0_upd = cfg_update; o0_rdy = s_ready; o0_cfg = cfg_out;
    tick();
    o1_upd = cfg_update; o1_err = err; o1_cfg = cfg_out;
    o1_valid = cfg_valid; o1_rdy = s_ready; o1_busy = busy;
    tick();
    o2_upd = cfg_update; o2_err = err; o2_rdy = s_ready; o2_busy = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; abort = 1'b0;
    #2;
    n_assert++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", s_ready); end
    n_assert++; if (cfg_out !== '0) begin n_fail++; $display("FAIL rst_cfg_out: got %h want 0", cfg_out); end
    n_assert++; if (cfg_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_valid: got %b want 0", cfg_valid); end
    n_assert++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_update: got %b want 0", cfg_update); end
    n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    tick();
    rst_n = 1'b1;
    n_assert++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_before_clk: got %b want 0", s_ready); end
    tick();
    n_assert++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_first_clk: got %b want 1", s_ready); end
  endtask

  task automatic test_commit_w9_one();
    for (int k = 0; k < 10; k++) pl[k] = '0;
    pl[9] = 16'h0001;
    run_frame(16'h0001);
    n_assert++; if (o0_upd !== 1'b0) begin n_fail++; $display("FAIL w9_upd_check_cycle: got %b want 0", o0_upd); end
    n_assert++; if (o0_cfg !== '0) begin n_fail++; $display("FAIL w9_cfg_early: got %h want 0", o0_cfg); end
    n_assert++; if (o0_rdy !== 1'b0) begin n_fail++; $display("FAIL w9_ready_check: got %b want 0", o0_rdy); end
    n_assert++; if (o1_upd !== 1'b1) begin n_fail++; $display("FAIL w9_upd_commit: got %b want 1", o1_upd); end
    n_assert++; if (o1_cfg !== CFG_W9_1) begin n_fail++; $display("FAIL w9_cfg_out: got %h want %h", o1_cfg, CFG_W9_1); end
    n_assert++; if (o1_valid !== 1'b1) begin n_fail++; $display("FAIL w9_cfg_valid: got %b want 1", o1_valid); end
    n_assert++; if (o1_rdy !== 1'b0) begin n_fail++; $display("FAIL w9_ready_commit: got %b want 0", o1_rdy); end
    n_assert++; if (o1_err !== 1'b0) begin n_fail++; $display("FAIL w9_err: got %b want 0", o1_err); end
    n_assert++; if (o2_upd !== 1'b0) begin n_fail++; $display("FAIL w9_upd_after: got %b want 0", o2_upd); end
    n_assert++; if (o2_rdy !== 1'b1) begin n_fail++; $display("FAIL w9_ready_idle: got %b want 1", o2_rdy); end
    n_assert++; if (o2_busy !== 1'b0) begin n_fail++; $display("FAIL w9_busy_idle: got %b want 0", o2_busy); end
  endtask

  task automatic test_upper_bits();
    for (int k = 0; k < 10; k++) pl[k] = '0;
    pl[9] = 16'h0004;
    run_frame(16'h0004);
    n_assert++; if (o1_err !== 1'b1) begin n_fail++; $display("FAIL upper_err: got %b want 1", o1_err); end
    n_assert++; if (o1_upd !== 1'b0) begin n_fail++; $display("FAIL upper_upd: got %b want 0", o1_upd); end
    n_assert++; if (o1_cfg !== CFG_W9_1) begin n_fail++; $display("FAIL upper_cfg_kept: got %h want %h", o1_cfg, CFG_W9_1); end
    n_assert++; if (o1_busy !== 1'b0) begin n_fail++; $display("FAIL upper_busy: got %b want 0", o1_busy); end
    n_assert++; if (o1_rdy !== 1'b1) begin n_fail++; $display("FAIL upper_ready: got %b want 1", o1_rdy); end
    n_assert++; if (o2_err !== 1'b0) begin n_fail++; $display("FAIL upper_err_pulse: got %b want 0", o2_err); end
  endtask

  task automatic test_commit_w9_three();
    for (int k = 0; k < 10; k++) pl[k] = '0;
    pl[9] = 16'h0003;
    run_frame(16'h0003);
    n_assert++; if (o1_err !== 1'b0) begin n_fail++; $display("FAIL w9x3_err: got %b want 0", o1_err); end
    n_assert++; if (o1_cfg !== CFG_W9_3) begin n_fail++; $display("FAIL w9x3_cfg_out: got %h want %h", o1_cfg, CFG_W9_3); end
  endtask

  task automatic test_bad_header();
    send_word(16'h1234);
    n_assert++; if (err !== 1'b1) begin n_fail++; $display("FAIL badhdr_err: got %b want 1", err); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL badhdr_busy: got %b want 0", busy); end
    n_assert++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL badhdr_ready: got %b want 1", s_ready); end
    tick();
    n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL badhdr_err_pulse: got %b want 0", err); end
    pl = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'hA5A5,
           16'h5A5A, 16'h0F0F, 16'hF0F0, 16'h1357, 16'h0002};
    run_frame(pl_xor());
    n_assert++; if (o1_upd !== 1'b1) begin n_fail++; $display("FAIL badhdr_next_upd: got %b want 1", o1_upd); end
    n_assert++; if (o1_cfg !== pl_pack()) begin n_fail++; $display("FAIL badhdr_next_cfg: got %h want %h", o1_cfg, pl_pack()); end
  endtask

  task automatic test_bad_checksum();
    logic [145:0] prior;
    prior = pl_pack();
    for (int k = 0; k < 10; k++) pl[k] = '0;
    pl[0] = 16'hFFFF;
    run_frame(16'hFFFE);
    n_assert++; if (o1_err !== 1'b1) begin n_fail++; $display("FAIL badcsum_err: got %b want 1", o1_err); end
    n_assert++; if (o1_upd !== 1'b0) begin n_fail++; $display("FAIL badcsum_upd: got %b want 0", o1_upd); end
    n_assert++; if (o1_cfg !== prior) begin n_fail++; $display("FAIL badcsum_cfg_kept: got %h want %h", o1_cfg, prior); end
    n_assert++; if (o1_valid !== 1'b1) begin n_fail++; $display("FAIL badcsum_valid: got %b want 1", o1_valid); end
    n_assert++; if (o0_upd !== 1'b0) begin n_fail++; $display("FAIL badcsum_upd_check: got %b want 0", o0_upd); end
  endtask

  task automatic test_abort();
    logic [145:0] prior;
    prior = cfg_out;
    pl = '{16'hDEAD, 16'hBEEF, 16'h0000, 16'hFFFF, 16'h8001,
           16'h7FFE, 16'h3C3C, 16'hC3C3, 16'h2468, 16'h0001};
    send_word(MAGIC);
    for (int k = 0; k < 6; k++) send_word(pl[k]);
    n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b want 1", busy); end
    abort = 1'b1; s_valid = 1'b1; s_data = pl[6];
    tick();
    abort = 1'b0; s_valid = 1'b0;
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b want 0", err); end
    n_assert++; if (cfg_out !== prior) begin n_fail++; $display("FAIL abort_cfg_kept: got %h want %h", cfg_out, prior); end
    tick();
    n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL abort_err_late: got %b want 0", err); end
    run_frame(pl_xor());
    n_assert++; if (o1_upd !== 1'b1) begin n_fail++; $display("FAIL abort_fresh_upd: got %b want 1", o1_upd); end
    n_assert++; if (o1_cfg !== pl_pack()) begin n_fail++; $display("FAIL abort_fresh_cfg: got %h want %h", o1_cfg, pl_pack()); end
  endtask

  task automatic test_backpressure();
    pl = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'hA5A5,
           16'h5A5A, 16'h0F0F, 16'hF0F0, 16'h1357, 16'h0002};
    bp_mode = 1;
    rdy_low_cnt = 0;
    run_frame(pl_xor());
    bp_mode = 0;
    n_assert++; if (o1_cfg !== pl_pack()) begin n_fail++; $display("FAIL bp_cfg: got %h want %h", o1_cfg, pl_pack()); end
    n_assert++; if (o1_upd !== 1'b1) begin n_fail++; $display("FAIL bp_upd: got %b want 1", o1_upd); end
    n_assert++; if (rdy_low_cnt !== 0) begin n_fail++; $display("FAIL bp_ready_gaps: got %0d low cycles want 0", rdy_low_cnt); end
    n_assert++; if (o0_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_ready_check: got %b want 0", o0_rdy); end
    n_assert++; if (o1_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_ready_commit: got %b want 0", o1_rdy); end
    n_assert++; if (o2_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_ready_idle: got %b want 1", o2_rdy); end
  endtask

  task automatic test_reset_midload();
    send_word(MAGIC);
    for (int k = 0; k < 3; k++) send_word(16'h1111);
    #2;
    rst_n = 1'b0;
    #1;
    n_assert++; if (cfg_out !== '0) begin n_fail++; $display("FAIL midrst_cfg_out: got %h want 0", cfg_out); end
    n_assert++; if (cfg_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", cfg_valid); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_assert++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b want 0", s_ready); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_commit_w9_one();
    test_upper_bits();
    test_commit_w9_three();
    test_bad_header();
    test_bad_checksum();
    test_abort();
    test_backpressure();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
